// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline types for the hazard scoreboard.
//   sb_entry_t : one tracked in-flight instruction {v, rd, we, ld}
//   FWD_*      : forwarding-select encoding (0 = register file, k = stage k)
//   ZERO_REG_DEF : register index that never produces a hazard (XZR)
package cpu_pipe_pkg;

   localparam int SB_REG_W     = 5;
   localparam int ZERO_REG_DEF = 31;

   localparam logic [1:0] FWD_RF  = 2'd0;
   localparam logic [1:0] FWD_EX  = 2'd1;
   localparam logic [1:0] FWD_MEM = 2'd2;
   localparam logic [1:0] FWD_WB  = 2'd3;

   typedef struct packed {
      logic                v;
      logic [SB_REG_W-1:0] rd;
      logic                we;
      logic                ld;
   } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// RF-stage request / hazard-control response bundle.
//   master : pipeline side, drives the RF instruction fields and ex_br_taken,
//            receives forwarding selects, stall/bubble/flush and stall_cnt.
//   slave  : the hazard scoreboard.
interface hazard_scoreboard_if #(
   parameter int REG_W = 5,
   parameter int DEPTH = 3,
   parameter int CNT_W = 32
);
   localparam int SEL_W = $clog2(DEPTH + 1);

   logic             rf_valid;
   logic [REG_W-1:0] rf_rn;
   logic [REG_W-1:0] rf_rm;
   logic             rf_rn_used;
   logic             rf_rm_used;
   logic [REG_W-1:0] rf_rd;
   logic             rf_we;
   logic             rf_load;
   logic             ex_br_taken;
   logic [SEL_W-1:0] fwd_sel_a;
   logic [SEL_W-1:0] fwd_sel_b;
   logic             stall;
   logic             bubble;
   logic             flush;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      output rf_valid, rf_rn, rf_rm, rf_rn_used, rf_rm_used, rf_rd, rf_we, rf_load, ex_br_taken,
      input  fwd_sel_a, fwd_sel_b, stall, bubble, flush, stall_cnt
   );

   modport slave (
      input  rf_valid, rf_rn, rf_rm, rf_rn_used, rf_rm_used, rf_rd, rf_we, rf_load, ex_br_taken,
      output fwd_sel_a, fwd_sel_b, stall, bubble, flush, stall_cnt
   );
endinterface

// File: rtl/hazard_match.sv
// Per-source priority matcher: finds the youngest in-flight producer of src.
// Ports:
//   ents    : tracked entries, index 0 = EX (youngest) .. DEPTH-1 = oldest
//   src     : source register index; srcUsed: source actually read
//   rfValid : RF stage holds a real instruction
//   fwdSel  : 0 = register file, k = forward from stage k
//   loadHit : youngest producer is a load still in EX (load-use hazard)
module hazard_match
   import cpu_pipe_pkg::*;
#(
   parameter int REG_W    = 5,
   parameter int DEPTH    = 3,
   parameter int ZERO_REG = ZERO_REG_DEF,
   parameter int SEL_W    = 2
) (
   input  sb_entry_t        ents [DEPTH],
   input  logic [REG_W-1:0] src,
   input  logic             srcUsed,
   input  logic             rfValid,
   output logic [SEL_W-1:0] fwdSel,
   output logic             loadHit
);

   logic [DEPTH-1:0] hit;

   always_comb begin
      hit     = '0;
      fwdSel  = '0;
      loadHit = 1'b0;
      // Walk oldest to youngest so the youngest producer overwrites the select.
      for (int k = DEPTH - 1; k >= 0; k--) begin
         hit[k] = ents[k].v && ents[k].we && (ents[k].rd == SB_REG_W'(src)) &&
                  (src != REG_W'(ZERO_REG)) && srcUsed && rfValid;
         if (hit[k]) fwdSel = SEL_W'(k + 1);
      end
      // A load in EX has no result yet; read the RF and let the stall resolve it.
      loadHit = hit[0] && ents[0].ld;
      if (loadHit) fwdSel = '0;
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding controller beside the RF stage. Tracks in-flight
// register writes for DEPTH stages after RF and produces forwarding selects,
// load-use stall, bubble insertion, branch flush and a saturating stall count.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   sb    : hazard_scoreboard_if.slave (RF instruction in, hazard control out)
// Build option:
//   HAZARD_DELAY_SLOT_EN : one architectural branch delay slot; a taken branch
//                          never flushes or bubbles the RF instruction.
module hazard_scoreboard
   import cpu_pipe_pkg::*;
#(
   parameter int REG_W    = 5,
   parameter int DEPTH    = 3,
   parameter int ZERO_REG = ZERO_REG_DEF,
   parameter int CNT_W    = 32
) (
   input logic               clk,
   input logic               reset,
   hazard_scoreboard_if.slave sb
);

   localparam int SEL_W = $clog2(DEPTH + 1);

   sb_entry_t        ents [DEPTH];
   logic [SEL_W-1:0] selA;
   logic [SEL_W-1:0] selB;
   logic             loadHitA;
   logic             loadHitB;
   logic             loadUse;
   logic             stallC;
   logic             bubbleC;
   logic             flushC;
   logic [CNT_W-1:0] stallCnt;

   hazard_match #(.REG_W(REG_W), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG), .SEL_W(SEL_W)) uMatchA (
      .ents    (ents),
      .src     (sb.rf_rn),
      .srcUsed (sb.rf_rn_used),
      .rfValid (sb.rf_valid),
      .fwdSel  (selA),
      .loadHit (loadHitA)
   );

   hazard_match #(.REG_W(REG_W), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG), .SEL_W(SEL_W)) uMatchB (
      .ents    (ents),
      .src     (sb.rf_rm),
      .srcUsed (sb.rf_rm_used),
      .rfValid (sb.rf_valid),
      .fwdSel  (selB),
      .loadHit (loadHitB)
   );

   assign loadUse = loadHitA | loadHitB;

`ifdef HAZARD_DELAY_SLOT_EN
   // The delay-slot instruction always executes; the fetch logic squashes IF.
   logic unusedBrTaken;
   assign unusedBrTaken = sb.ex_br_taken;

   always_comb begin
      flushC  = 1'b0;
      stallC  = loadUse;
      bubbleC = loadUse;
   end
`else
   // A squashed instruction must not hold the front end, so flush wins.
   always_comb begin
      flushC  = sb.ex_br_taken;
      stallC  = loadUse & ~sb.ex_br_taken;
      bubbleC = loadUse | sb.ex_br_taken;
   end
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < DEPTH; k++) ents[k] <= '0;
         stallCnt <= '0;
      end else begin
         for (int k = DEPTH - 1; k > 0; k--) ents[k] <= ents[k-1];
         if (bubbleC) begin
            ents[0] <= '0;
         end else begin
            ents[0] <= '{v: sb.rf_valid, rd: SB_REG_W'(sb.rf_rd), we: sb.rf_we, ld: sb.rf_load};
         end
         if (stallC && (stallCnt != '1)) stallCnt <= stallCnt + CNT_W'(1);
      end
   end

   assign sb.fwd_sel_a = selA;
   assign sb.fwd_sel_b = selB;
   assign sb.stall     = stallC;
   assign sb.bubble    = bubbleC;
   assign sb.flush     = flushC;
   assign sb.stall_cnt = stallCnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a default-width instance and a
// CNT_W=4 instance driven with identical RF traffic.
module tb_hazard_scoreboard;
   import cpu_pipe_pkg::*;

`ifdef HAZARD_DELAY_SLOT_EN
   localparam bit DS = 1'b1;
`else
   localparam bit DS = 1'b0;
`endif

   logic clk;
   logic reset;
   int   total;
   int   bad;

   hazard_scoreboard_if #(.REG_W(5), .DEPTH(3), .CNT_W(32)) s32 ();
   hazard_scoreboard_if #(.REG_W(5), .DEPTH(3), .CNT_W(4))  s4 ();

   hazard_scoreboard #(.REG_W(5), .DEPTH(3), .ZERO_REG(31), .CNT_W(32)) dut32 (
      .clk   (clk),
      .reset (reset),
      .sb    (s32.slave)
   );

   hazard_scoreboard #(.REG_W(5), .DEPTH(3), .ZERO_REG(31), .CNT_W(4)) dut4 (
      .clk   (clk),
      .reset (reset),
      .sb    (s4.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic rf(input logic v, input logic [4:0] rn, input logic rnU,
                     input logic [4:0] rm, input logic rmU, input logic [4:0] rd,
                     input logic we, input logic ld, input logic br);
      s32.rf_valid = v;  s4.rf_valid = v;
      s32.rf_rn = rn;    s4.rf_rn = rn;
      s32.rf_rn_used = rnU; s4.rf_rn_used = rnU;
      s32.rf_rm = rm;    s4.rf_rm = rm;
      s32.rf_rm_used = rmU; s4.rf_rm_used = rmU;
      s32.rf_rd = rd;    s4.rf_rd = rd;
      s32.rf_we = we;    s4.rf_we = we;
      s32.rf_load = ld;  s4.rf_load = ld;
      s32.ex_br_taken = br; s4.ex_br_taken = br;
   endtask

   // drive on the falling edge, sample combinational outputs 1 time unit later
   task automatic cyc(input logic v, input logic [4:0] rn, input logic rnU,
                      input logic [4:0] rm, input logic rmU, input logic [4:0] rd,
                      input logic we, input logic ld, input logic br);
      @(negedge clk);
      rf(v, rn, rnU, rm, rmU, rd, we, ld, br);
      #1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b0;
      rf(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      chk("rst_fwd_a", 32'(s32.fwd_sel_a), FWD_RF);
      chk("rst_fwd_b", 32'(s32.fwd_sel_b), FWD_RF);
      chk("rst_stall", 32'(s32.stall), 0);
      chk("rst_bubble", 32'(s32.bubble), 0);
      chk("rst_flush", 32'(s32.flush), 0);
      chk("rst_cnt", s32.stall_cnt, 0);

      @(negedge clk);
      reset = 1'b1;
      // ADDI X1, X0, #imm
      rf(1, 0, 1, 0, 0, 1, 1, 0, 0);
      #1;
      chk("addi_fwd_a", 32'(s32.fwd_sel_a), FWD_RF);
      // ADD X2, X1, X3
      cyc(1, 1, 1, 3, 1, 2, 1, 0, 0);
      chk("ex_fwd_a", 32'(s32.fwd_sel_a), FWD_EX);
      chk("ex_fwd_b", 32'(s32.fwd_sel_b), FWD_RF);
      chk("ex_stall", 32'(s32.stall), 0);
      // ADD X8, X1, X3 : X1 now in MEM
      cyc(1, 1, 1, 3, 1, 8, 1, 0, 0);
      chk("mem_fwd_a", 32'(s32.fwd_sel_a), FWD_MEM);
      chk("mem_fwd_b", 32'(s32.fwd_sel_b), FWD_RF);

      // priority: X5, X10, X5 writers
      cyc(1, 0, 0, 0, 0, 5, 1, 0, 0);
      cyc(1, 0, 0, 0, 0, 10, 1, 0, 0);
      cyc(1, 0, 0, 5, 1, 5, 1, 0, 0);
      chk("x5_mem_fwd_b", 32'(s32.fwd_sel_b), FWD_MEM);
      cyc(1, 5, 1, 10, 1, 0, 0, 0, 0);
      chk("prio_fwd_a", 32'(s32.fwd_sel_a), FWD_EX);
      chk("prio_fwd_b", 32'(s32.fwd_sel_b), FWD_MEM);

      // load-use: LDUR X4 ; SUB X6, X4, X4
      cyc(1, 9, 1, 0, 0, 4, 1, 1, 0);
      chk("ldur_stall", 32'(s32.stall), 0);
      cyc(1, 4, 1, 4, 1, 6, 1, 0, 0);
      chk("lu_stall", 32'(s32.stall), 1);
      chk("lu_bubble", 32'(s32.bubble), 1);
      chk("lu_flush", 32'(s32.flush), 0);
      chk("lu_fwd_a", 32'(s32.fwd_sel_a), FWD_RF);
      chk("lu_fwd_b", 32'(s32.fwd_sel_b), FWD_RF);
      chk("lu_cnt_pre", s32.stall_cnt, 0);
      cyc(1, 4, 1, 4, 1, 6, 1, 0, 0);
      chk("lu2_stall", 32'(s32.stall), 0);
      chk("lu2_bubble", 32'(s32.bubble), 0);
      chk("lu2_fwd_a", 32'(s32.fwd_sel_a), FWD_MEM);
      chk("lu2_fwd_b", 32'(s32.fwd_sel_b), FWD_MEM);
      chk("lu2_cnt32", s32.stall_cnt, 1);
      chk("lu2_cnt4", 32'(s4.stall_cnt), 1);

      // XZR writer, then X7 writer while reading X31
      cyc(1, 0, 0, 0, 0, 31, 1, 0, 0);
      cyc(1, 31, 1, 0, 0, 7, 1, 0, 0);
      chk("xzr_fwd_a", 32'(s32.fwd_sel_a), FWD_RF);
      cyc(1, 31, 1, 7, 0, 0, 0, 0, 0);
      chk("xzr2_fwd_a", 32'(s32.fwd_sel_a), FWD_RF);
      chk("unused_fwd_b", 32'(s32.fwd_sel_b), FWD_RF);
      chk("unused_stall", 32'(s32.stall), 0);
      cyc(1, 0, 0, 7, 1, 0, 0, 0, 0);
      chk("x7_fwd_b", 32'(s32.fwd_sel_b), FWD_MEM);
      cyc(1, 7, 1, 0, 0, 0, 0, 0, 0);
      chk("wb_fwd_a", 32'(s32.fwd_sel_a), FWD_WB);

      // branch taken coinciding with load-use
      cyc(1, 9, 1, 0, 0, 4, 1, 1, 0);
      cyc(1, 4, 1, 4, 1, 6, 1, 0, 1);
      chk("br_flush", 32'(s32.flush), DS ? 0 : 1);
      chk("br_bubble", 32'(s32.bubble), 1);
      chk("br_stall", 32'(s32.stall), DS ? 1 : 0);
      // rf_valid=0 while the load sits in MEM
      cyc(0, 4, 1, 4, 1, 0, 0, 0, 0);
      chk("inv_fwd_a", 32'(s32.fwd_sel_a), FWD_RF);
      chk("inv_flush", 32'(s32.flush), 0);
      chk("br_cnt", s32.stall_cnt, DS ? 2 : 1);
      // rf_valid=0 right behind a load
      cyc(1, 9, 1, 0, 0, 4, 1, 1, 0);
      cyc(0, 4, 1, 4, 1, 6, 1, 0, 0);
      chk("inv_stall", 32'(s32.stall), 0);
      chk("inv_bubble", 32'(s32.bubble), 0);

      // reset asserted mid-stall
      cyc(1, 9, 1, 0, 0, 4, 1, 1, 0);
      cyc(1, 4, 1, 4, 1, 6, 1, 0, 0);
      chk("pre_rst_stall", 32'(s32.stall), 1);
      reset = 1'b0;
      #1;
      chk("midrst_stall", 32'(s32.stall), 0);
      chk("midrst_bubble", 32'(s32.bubble), 0);
      chk("midrst_cnt32", s32.stall_cnt, 0);
      chk("midrst_cnt4", 32'(s4.stall_cnt), 0);

      // saturation: 20 load-use stalls after reset release
      @(negedge clk);
      reset = 1'b1;
      rf(1, 9, 1, 0, 0, 4, 1, 1, 0);
      #1;
      cyc(1, 4, 1, 4, 1, 6, 1, 0, 0);
      chk("sat_stall_0", 32'(s32.stall), 1);
      for (int i = 1; i < 20; i++) begin
         cyc(1, 9, 1, 0, 0, 4, 1, 1, 0);
         cyc(1, 4, 1, 4, 1, 6, 1, 0, 0);
         chk($sformatf("sat_stall_%0d", i), 32'(s4.stall), 1);
      end
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("sat_cnt32", s32.stall_cnt, 20);
      chk("sat_cnt4", 32'(s4.stall_cnt), 15);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard and forwarding controller for the pipelined CPU.
- Sits beside the RF stage and tracks in-flight register writes across a configurable number of downstream stages (default EX, MEM, WB).
- Each cycle it produces forwarding selects, load-use stalls, bubble insertion and branch flush for the stage registers.
- Replaces the free-running, always-enabled stage registers with controlled ones.

Parameters:
- REG_W, 5: register index width.
- DEPTH, 3: tracked stages after RF; stage 1 = EX (youngest), stage DEPTH = WB (oldest).
- ZERO_REG, 31: register that never creates a hazard (XZR).
- CNT_W, 32: stall-counter width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- rf_valid  in  1  RF stage holds a real instruction.
- rf_rn  in  REG_W  source A index.
- rf_rm  in  REG_W  source B index.
- rf_rn_used  in  1  source A is read.
- rf_rm_used  in  1  source B is read.
- rf_rd  in  REG_W  destination index.
- rf_we  in  1  instruction writes rf_rd.
- rf_load  in  1  instruction is a load (result ready only after MEM).
- ex_br_taken  in  1  branch resolved taken in EX this cycle.
- fwd_sel_a  out  $clog2(DEPTH+1)  0 = register file, k = stage k result.
- fwd_sel_b  out  $clog2(DEPTH+1)  same encoding, for source B.
- stall  out  1  hold PC and the IF/RF register.
- bubble  out  1  load a NOP into the RF/EX register.
- flush  out  1  squash the IF/RF register.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- State is an array of DEPTH entries {v, rd, we, ld}.
- Each clock edge every entry shifts one stage older; entry DEPTH is discarded.
- The value loaded into entry 1:
  - normal cycle: {rf_valid, rf_rd, rf_we, rf_load};
  - cycle with bubble or flush: v=0.
- Reset (async, active-low): all v=0, stall_cnt=0. All outputs are then 0 (combinational from cleared state).
- Hit definition: entry k is a hit for source X when v & we & rd==X & X!=ZERO_REG & X_used & rf_valid.
- Forwarding:
  - fwd_sel_X = smallest k that hits (youngest producer wins); 0 if no hit.
  - Combinational, valid in the same cycle the inputs are presented.
- Load-use:
  - If entry 1 hits and has ld=1 on either source: stall=1, bubble=1, and the affected fwd_sel is forced to 0.
  - The next cycle the load sits in stage 2, so forwarding from stage 2 resolves it. Load-use is therefore exactly 1 stall cycle.
- Branch flush (without DELAY_SLOT_EN):
  - ex_br_taken=1 gives flush=1 and bubble=1, and forces stall=0.
  - Flush overrides a simultaneous load-use stall, because the stalled instruction is being squashed.
- stall_cnt:
  - increments on each edge where stall=1;
  - saturates at all-ones and does not wrap.
- rf_valid=0: no hits, stall=0; a v=0 entry is inserted.
- Reset asserted mid-stall: state clears immediately, stall drops the same cycle.

Optional Feature:
- Macro: HAZARD_DELAY_SLOT_EN.
- Defined: one architectural branch delay slot.
  - ex_br_taken never asserts flush or bubble.
  - The RF instruction proceeds normally, and a load-use stall on it is still honoured.
  - The IF-stage instruction is squashed by the fetch logic, not by this block.
- Undefined: flush behaviour as in Behaviour.

Decomposition:
- Shared package cpu_pipe_pkg:
  - sb_entry_t struct {v, rd, we, ld};
  - fwd_sel encoding constants FWD_RF=0, FWD_EX=1, FWD_MEM=2, FWD_WB=3;
  - ZERO_REG default.
- One natural sub-module: hazard_match. It is the combinational per-source priority matcher, instantiated twice (A and B), and outputs fwd_sel and load_hit.
- Shift array and counter stay in the top.

Test Plan:
- Forward from EX: ADDI X1 then ADD X2,X1,X3 back-to-back -> fwd_sel_a=1, stall=0. Next cycle with X1 in MEM and no newer write -> fwd_sel_a=2.
- Priority: writes to X5 in stages 3 and 1, RF reads X5 -> fwd_sel_a=1.
- Load-use: LDUR X4 then SUB X6,X4,X4 -> one cycle with stall=1, bubble=1, fwd_sel_a=fwd_sel_b=0, stall_cnt 0->1. Next cycle stall=0, fwd_sel_a=fwd_sel_b=2.
- XZR and unused: writer to X31 with RF reading X31, and a writer to X7 with rf_rm=7 but rf_rm_used=0 -> both fwd_sel=0, stall=0.
- Branch: ex_br_taken=1 coinciding with a load-use condition -> flush=1, bubble=1, stall=0. With HAZARD_DELAY_SLOT_EN defined -> flush=0, stall=1.
- Reset/saturation: drive reset low during a stall -> stall=0 immediately, stall_cnt=0. With CNT_W=4, hold 20 stall cycles -> stall_cnt=15.
